// File: rtl/timer_core.sv
// Prescaled 32-bit down-counter with a sticky expiry flag.
// Define TIMER_AUTO_RELOAD_EN for periodic operation; otherwise the timer is one-shot.
module timer_core #(
   parameter int PRESCALE_WIDTH = 8,
   parameter int PRESCALE       = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        timer_enable,
   input  logic [31:0] timer_count,
   input  logic        timer_interrupt_clear,
   output logic        timer_interrupt,
   output logic [31:0] timer_value,
   output logic        timer_running
);

   // state | meaning
   // IDLE  | stopped, waiting for an enable rising edge to load
   // RUN   | counting down on prescaler ticks
   // DONE  | one-shot expired; waits for enable low before returning to IDLE
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_TC = PRESCALE_WIDTH'(PRESCALE);

   state_t                    state_q, state_d;
   logic [31:0]               value_q, value_d;
   logic [PRESCALE_WIDTH-1:0] prescaler_q, prescaler_d;
   logic                      enable_d;
   logic                      irq_q, irq_d;
   logic                      enable_rise;
   logic                      tick;
   logic                      expire;

   assign enable_rise = timer_enable & ~enable_d;
   assign tick        = (prescaler_q == PRESCALE_TC);

   always_comb begin
      state_d     = state_q;
      value_d     = value_q;
      prescaler_d = prescaler_q;
      expire      = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable_rise) begin
               state_d     = RUN;
               value_d     = timer_count;
               prescaler_d = '0;
            end
         end
         RUN: begin
            if (!timer_enable) begin
               state_d     = IDLE;
               prescaler_d = '0;
            end else if (tick) begin
               prescaler_d = '0;
               if (value_q != 32'd0) begin
                  value_d = value_q - 32'd1;
               end else begin
                  expire = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                  value_d = timer_count;
`else
                  state_d = DONE;
                  value_d = 32'd0;
`endif
               end
            end else begin
               prescaler_d = prescaler_q + PRESCALE_WIDTH'(1);
            end
         end
         DONE: begin
            value_d = 32'd0;
            if (!timer_enable) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Clear wins over a simultaneous expiry, so that expiry is dropped.
   always_comb begin
      irq_d = irq_q;
      if (timer_interrupt_clear) begin
         irq_d = 1'b0;
      end else if (expire) begin
         irq_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         value_q     <= 32'd0;
         prescaler_q <= '0;
         enable_d    <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         value_q     <= value_d;
         prescaler_q <= prescaler_d;
         enable_d    <= timer_enable;
         irq_q       <= irq_d;
      end
   end

   assign timer_interrupt = irq_q;
   assign timer_value     = value_q;
   assign timer_running   = (state_q == RUN);

endmodule

// File: tb/tb_timer_core.sv
// Directed bench for timer_core: one instance with PRESCALE=0, one with PRESCALE=3.
// Expected {interrupt, running, value} triples go through a scoreboard queue.
module tb_timer_core;

`ifdef TIMER_AUTO_RELOAD_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic        clk;
   logic        reset_a, en_a, clr_a;
   logic [31:0] cnt_a;
   logic        irq_a, run_a;
   logic [31:0] val_a;
   logic        reset_p, en_p, clr_p;
   logic [31:0] cnt_p;
   logic        irq_p, run_p;
   logic [31:0] val_p;

   int passed = 0;
   int total  = 0;

   typedef struct {
      string       tag;
      logic [33:0] exp;
   } sb_t;
   sb_t sb[$];

   timer_core #(.PRESCALE_WIDTH(8), .PRESCALE(0)) dut (
      .clk                  (clk),
      .reset                (reset_a),
      .timer_enable         (en_a),
      .timer_count          (cnt_a),
      .timer_interrupt_clear(clr_a),
      .timer_interrupt      (irq_a),
      .timer_value          (val_a),
      .timer_running        (run_a)
   );

   timer_core #(.PRESCALE_WIDTH(8), .PRESCALE(3)) dut_p (
      .clk                  (clk),
      .reset                (reset_p),
      .timer_enable         (en_p),
      .timer_count          (cnt_p),
      .timer_interrupt_clear(clr_p),
      .timer_interrupt      (irq_p),
      .timer_value          (val_p),
      .timer_running        (run_p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input bit sel, input logic rst, input logic en, input logic [31:0] cnt,
                       input logic clr, input logic e_irq, input logic e_run,
                       input logic [31:0] e_val, input string tag);
      sb_t         e;
      logic [33:0] obs;
      if (!sel) begin
         reset_a = rst; en_a = en; cnt_a = cnt; clr_a = clr;
      end else begin
         reset_p = rst; en_p = en; cnt_p = cnt; clr_p = clr;
      end
      e.tag = tag;
      e.exp = {e_irq, e_run, e_val};
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e   = sb.pop_front();
      obs = sel ? {irq_p, run_p, val_p} : {irq_a, run_a, val_a};
      total++;
      assert (obs === e.exp) passed++;
      else $error("FAIL %s: observed irq/run/value=%h expected=%h", e.tag, obs, e.exp);
   endtask

   task automatic a(input logic rst, input logic en, input logic [31:0] cnt, input logic clr,
                    input logic e_irq, input logic e_run, input logic [31:0] e_val,
                    input string tag);
      step(1'b0, rst, en, cnt, clr, e_irq, e_run, e_val, tag);
   endtask

   task automatic p(input logic rst, input logic en, input logic [31:0] cnt, input logic clr,
                    input logic e_irq, input logic e_run, input logic [31:0] e_val,
                    input string tag);
      step(1'b1, rst, en, cnt, clr, e_irq, e_run, e_val, tag);
   endtask

   initial begin
      reset_a = 1'b1; en_a = 1'b0; cnt_a = 32'd0; clr_a = 1'b0;
      reset_p = 1'b1; en_p = 1'b0; cnt_p = 32'd0; clr_p = 1'b0;

      // reset with enable already high; release sees a rising edge
      a(1, 1, 5, 0, 0, 0, 0, "rst_cyc0");
      a(1, 1, 5, 0, 0, 0, 0, "rst_cyc1");
      a(0, 1, 5, 0, 0, 1, 5, "load_after_rst");
      a(0, 0, 5, 0, 0, 0, 5, "stop_hold5");

      // N=3, PRESCALE=0
      a(0, 1, 3, 0, 0, 1, 3, "n3_e0");
      a(0, 1, 3, 0, 0, 1, 2, "n3_e1");
      a(0, 1, 3, 0, 0, 1, 1, "n3_e2");
      a(0, 1, 3, 0, 0, 1, 0, "n3_e3");
      a(0, 1, 3, 0, 1, AR, AR ? 32'd3 : 32'd0, "n3_expire_e4");
      a(0, 1, 3, 1, 0, AR, AR ? 32'd2 : 32'd0, "n3_clear_e5");
      a(0, 1, 3, 0, 0, AR, AR ? 32'd1 : 32'd0, "n3_e6");
      a(0, 1, 3, 0, 0, AR, 0, "n3_e7");
      a(0, 1, 3, 0, AR, AR, AR ? 32'd3 : 32'd0, "n3_second_e8");
      a(0, 0, 3, 0, AR, 0, AR ? 32'd3 : 32'd0, "stop_sticky");

      // N=10: stop after four ticks, flag persists across restart
      a(0, 1, 10, 0, AR, 1, 10, "n10_load");
      a(0, 1, 10, 0, AR, 1, 9, "n10_t1");
      a(0, 1, 10, 0, AR, 1, 8, "n10_t2");
      a(0, 1, 10, 0, AR, 1, 7, "n10_t3");
      a(0, 1, 10, 0, AR, 1, 6, "n10_t4");
      a(0, 0, 10, 0, AR, 0, 6, "n10_freeze");
      a(0, 0, 10, 1, 0, 0, 6, "clear_idle");
      a(0, 1, 10, 0, 0, 1, 10, "n10_reload");
      // count input changes mid-run are ignored until reload
      for (int i = 0; i < 10; i++) begin
         a(0, 1, 20, 0, 0, 1, 32'(9 - i), "n10_count");
      end
      a(0, 1, 20, 0, 1, AR, AR ? 32'd20 : 32'd0, "n10_expire");

      // clear held through expiry: expiry lost
      a(0, 0, 20, 0, 1, 0, AR ? 32'd20 : 32'd0, "stop_after_n10");
      a(0, 0, 20, 1, 0, 0, AR ? 32'd20 : 32'd0, "clear_idle2");
      a(0, 1, 2, 1, 0, 1, 2, "n2_load");
      a(0, 1, 2, 1, 0, 1, 1, "n2_t1");
      a(0, 1, 2, 1, 0, 1, 0, "n2_t2");
      a(0, 1, 2, 1, 0, AR, AR ? 32'd2 : 32'd0, "n2_clear_wins");
      a(0, 1, 2, 0, 0, AR, AR ? 32'd1 : 32'd0, "n2_after_expiry");
      a(0, 1, 2, 0, 0, AR, 0, "n2_after_expiry2");
      a(0, 0, 2, 0, 0, 0, 0, "n2_stop");
      a(0, 1, 2, 0, 0, 1, 2, "n2_restart");

      // reset mid-run at value 7
      a(0, 0, 9, 0, 0, 0, 2, "pre_n9_stop");
      a(0, 1, 9, 0, 0, 1, 9, "n9_load");
      a(0, 1, 9, 0, 0, 1, 8, "n9_t1");
      a(0, 1, 9, 0, 0, 1, 7, "n9_t2");
      a(1, 1, 9, 0, 0, 0, 0, "reset_mid_run");
      for (int i = 0; i < 12; i++) begin
         a(0, 0, 9, 0, 0, 0, 0, "post_reset_quiet");
      end

      // PRESCALE=3, N=1: value moves every 4th cycle, expiry at load+8
      p(1, 1, 1, 0, 0, 0, 0, "p_reset");
      p(0, 1, 1, 0, 0, 1, 1, "p_load");
      for (int i = 1; i < 4; i++) begin
         p(0, 1, 1, 0, 0, 1, 1, "p_hold1");
      end
      p(0, 1, 1, 0, 0, 1, 0, "p_tick4");
      for (int i = 5; i < 8; i++) begin
         p(0, 1, 1, 0, 0, 1, 0, "p_hold0");
      end
      p(0, 1, 1, 0, 1, AR, AR ? 32'd1 : 32'd0, "p_expire_e8");
      p(0, 1, 1, 0, 1, AR, AR ? 32'd1 : 32'd0, "p_after_expire");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/timer_core.md
Name: timer_core

Overview:
- Counting engine behind the Picoblaze timer register block.
- Consumes the register block's timer_enable, timer_count and timer_interrupt_clear outputs, and returns the timer_interrupt it samples.
- Implements a prescaled 32-bit down-counter with a sticky expiry flag.
- Periodic (auto-reload) or one-shot operation is selected at compile time.

Parameters:
- PRESCALE_WIDTH, 8: width of the prescaler counter.
- PRESCALE, 0: a tick occurs every PRESCALE+1 clk cycles; must fit in PRESCALE_WIDTH bits.

Ports:
- clk  input  1  system clock; all logic is on its rising edge
- reset  input  1  synchronous, active-high reset
- timer_enable  input  1  level; high runs the timer, low stops it
- timer_count  input  32  reload value N; period is N+1 ticks
- timer_interrupt_clear  input  1  level; while high, timer_interrupt is held at 0
- timer_interrupt  output  1  sticky expiry flag, registered
- timer_value  output  32  current counter contents, registered
- timer_running  output  1  high in state RUN

Behaviour:
- Reset (synchronous, active high, dominates every other input):
  - state=IDLE; timer_value=0; prescaler=0; enable_d=0; timer_interrupt=0; timer_running=0.
  - Reset asserted mid-run aborts the count on that edge; no expiry is generated.
- enable_d is a registered copy of timer_enable. A rising edge is detected as timer_enable & ~enable_d.
- States IDLE, RUN, DONE:
  - IDLE: on an enable rising edge -> RUN, timer_value<=timer_count, prescaler<=0.
  - RUN:
    - If timer_enable is low -> IDLE. timer_value holds; prescaler<=0.
    - Otherwise the prescaler increments each cycle. tick = (prescaler==PRESCALE); on a tick the prescaler wraps to 0.
    - On a tick with timer_value!=0: timer_value decrements by 1.
    - On a tick with timer_value==0: this is an expiry event. timer_interrupt<=1 unless the clear input is high. The next step depends on the optional feature.
  - DONE: timer_value=0; counting is halted.
    - Leave to IDLE only when timer_enable is low.
    - A new count requires a fresh enable rising edge.
- Timing: with PRESCALE=0 and N loaded at edge E0, expiry occurs at edge E(N+1). In general, expiry occurs (N+1)*(PRESCALE+1) edges after the load edge.
- N=0 expires on every tick.
- Changing timer_count while in RUN has no effect until the next load or reload.
- timer_interrupt_clear:
  - While high, timer_interrupt<=0 every cycle.
  - Clear has priority over a simultaneous expiry; that expiry is lost.
  - Clear does not affect counting or state.
- timer_interrupt is sticky: it stays 1 across stop/restart until cleared or reset.
- timer_running=1 exactly when state==RUN.
- No arithmetic wrap: the counter never decrements below 0. Reload replaces the decrement.

Optional Feature:
- Macro TIMER_AUTO_RELOAD_EN.
- Defined: on expiry in RUN, timer_value<=timer_count (current input value), the prescaler wraps, and the state stays RUN. The timer is periodic, with back-to-back periods of (N+1)*(PRESCALE+1) cycles.
- Undefined: on expiry, state<=DONE, timer_value stays 0 and timer_running falls on the same edge. The timer is one-shot.
- DONE is unreachable when TIMER_AUTO_RELOAD_EN is defined.

Test Plan:
1. Reset: assert reset 2 cycles with timer_enable=1 and timer_count=5 -> all outputs 0 and state IDLE. After release, the enable rising edge is seen because enable_d=0, so the counter loads 5.
2. PRESCALE=0, N=3, TIMER_AUTO_RELOAD_EN defined, enable rises at E0 -> timer_value 3,2,1,0 at E0..E3. timer_interrupt=1 after E4, timer_value=3 again. Pulse clear at E5 for 1 cycle -> interrupt 0 after E5. It sets again after E8.
3. PRESCALE=3, N=1 -> timer_value changes only every 4th cycle; timer_interrupt rises after edge load+8.
4. N=10, drop timer_enable after 4 ticks -> IDLE, timer_value frozen at 6, no interrupt. Re-raise timer_enable -> reload to 10 and the full 11-tick period runs before expiry.
5. Macro undefined, N=2: hold clear high through the expiry edge -> timer_interrupt stays 0; state DONE, timer_running=0, timer_value=0. Further cycles with enable high give no count. Dropping and re-raising enable restarts the count at 2.
6. Assert reset mid-run at timer_value=7 -> next cycle all outputs 0. No interrupt ever appears for the aborted count.
